// File: rtl/mode_switch_pkg.sv
// Shared types and helpers for the mode_switch button front end.
package mode_switch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESSED,
    ST_LONG_HELD
  } press_state_t;

  // Bits needed for a counter that spans 0..n-1.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/btn_press.sv
// One push-button: 2-flop synchroniser, debounce filter and short/long press classifier.
module btn_press
  import mode_switch_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES   = 1_000_000,
  parameter int unsigned LONG_PRESS_CYCLES = 50_000_000,
  parameter bit          BTN_ACTIVE_LOW    = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic short_pulse,
  output logic long_pulse
);

  localparam int unsigned DB_W   = cnt_width(DEBOUNCE_CYCLES);
  localparam int unsigned HOLD_W = cnt_width(LONG_PRESS_CYCLES);
  localparam logic RELEASED_RAW  = BTN_ACTIVE_LOW ? 1'b1 : 1'b0;

  logic              sync1;
  logic              sync2;
  logic              pressed;
  logic [DB_W-1:0]   db_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  press_state_t      state;

  // Synchroniser clears to the released level so reset never fakes a press.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= RELEASED_RAW;
      sync2 <= RELEASED_RAW;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  assign pressed = BTN_ACTIVE_LOW ? ~sync2 : sync2;

  // Accept a level change only after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      db_cnt <= '0;
      level  <= 1'b0;
    end else if (pressed != level) begin
      if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        level  <= pressed;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end else begin
      db_cnt <= '0;
    end
  end

  // Long fires on the edge the hold counter reaches LONG_PRESS_CYCLES-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      hold_cnt    <= '0;
      short_pulse <= 1'b0;
      long_pulse  <= 1'b0;
    end else begin
      short_pulse <= 1'b0;
      long_pulse  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (level) begin
            state    <= ST_PRESSED;
            hold_cnt <= '0;
          end
        end
        ST_PRESSED: begin
          if (!level) begin
            short_pulse <= 1'b1;
            state       <= ST_IDLE;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
            if (hold_cnt == HOLD_W'(LONG_PRESS_CYCLES - 2)) begin
              long_pulse <= 1'b1;
              state      <= ST_LONG_HELD;
            end
          end
        end
        ST_LONG_HELD: begin
          if (!level) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/mode_switch.sv
// Board input front end: debounced button events, wrapping mode register on button 0,
// and synchronised slide switches.
module mode_switch
  import mode_switch_pkg::*;
#(
  parameter int unsigned NUM_BTN           = 4,
  parameter int unsigned NUM_MODES         = 4,
  parameter int unsigned SW_WIDTH          = 7,
  parameter int unsigned DEBOUNCE_CYCLES   = 1_000_000,
  parameter int unsigned LONG_PRESS_CYCLES = 50_000_000,
  parameter bit          BTN_ACTIVE_LOW    = 1'b1,
  localparam int unsigned MODE_W           = cnt_width(NUM_MODES)
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [NUM_BTN-1:0]  BUTTON,
  input  logic [SW_WIDTH-1:0] SWITCH,
  output logic [MODE_W-1:0]   MODE,
  output logic                MODE_CHANGED,
  output logic [NUM_BTN-1:0]  BTN_SHORT,
  output logic [NUM_BTN-1:0]  BTN_LONG,
  output logic [NUM_BTN-1:0]  BTN_LEVEL,
  output logic [SW_WIDTH-1:0] SW_SYNC
);

  logic [SW_WIDTH-1:0] sw_meta;

  for (genvar i = 0; i < int'(NUM_BTN); i++) begin : g_btn
    btn_press #(
      .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
      .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES),
      .BTN_ACTIVE_LOW   (BTN_ACTIVE_LOW)
    ) u_btn (
      .clk        (CLK),
      .rst        (RST),
      .raw        (BUTTON[i]),
      .level      (BTN_LEVEL[i]),
      .short_pulse(BTN_SHORT[i]),
      .long_pulse (BTN_LONG[i])
    );
  end

  // Short press advances with explicit wrap; long press returns to mode 0.
  always_ff @(posedge CLK) begin
    if (RST) begin
      MODE         <= '0;
      MODE_CHANGED <= 1'b0;
    end else begin
      MODE_CHANGED <= 1'b0;
      if (BTN_SHORT[0]) begin
        MODE         <= (MODE == MODE_W'(NUM_MODES - 1)) ? '0 : MODE + MODE_W'(1);
        MODE_CHANGED <= 1'b1;
      end else if (BTN_LONG[0]) begin
        MODE         <= '0;
        MODE_CHANGED <= (MODE != '0);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sw_meta <= '0;
      SW_SYNC <= '0;
    end else begin
      sw_meta <= SWITCH;
      SW_SYNC <= sw_meta;
    end
  end

endmodule
